// File: rtl/sdhci_cmd_engine_if.sv
// Register-block side of the SDHCI command engine: request fields, handshake,
// completion pulse, captured response and error flags.
interface sdhci_cmd_engine_if;
   logic         cmd_valid_i;
   logic         cmd_ready_o;
   logic [5:0]   cmd_index_i;
   logic [31:0]  cmd_arg_i;
   logic [1:0]   rsp_type_i;
   logic         inhibit_o;
   logic         done_o;
   logic [119:0] rsp_o;
   logic         timeout_err_o;
   logic         crc_err_o;
   logic         end_err_o;
   logic         index_err_o;

   modport master (
      output cmd_valid_i, cmd_index_i, cmd_arg_i, rsp_type_i,
      input  cmd_ready_o, inhibit_o, done_o, rsp_o,
             timeout_err_o, crc_err_o, end_err_o, index_err_o
   );

   modport slave (
      input  cmd_valid_i, cmd_index_i, cmd_arg_i, rsp_type_i,
      output cmd_ready_o, inhibit_o, done_o, rsp_o,
             timeout_err_o, crc_err_o, end_err_o, index_err_o
   );
endinterface

// File: rtl/sdhci_cmd_engine.sv
// SD CMD-line engine: divides the system clock into sd_clk, shifts out one
// 48-bit command token and optionally captures a 48/136-bit response.
module sdhci_cmd_engine #(
   parameter int ClkDivWidth  = 10,
   parameter int TimeoutWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    sd_clk_en_i,
   input  logic [ClkDivWidth-1:0]  clk_div_i,
   input  logic [TimeoutWidth-1:0] timeout_i,
   sdhci_cmd_engine_if.slave       cmd,
   output logic                    sd_clk_o,
   output logic                    sd_cmd_o,
   output logic                    sd_cmd_oe_o,
   input  logic                    sd_cmd_i
);
   typedef enum logic [2:0] {IDLE, TX, WAIT_START, RX, DONE} state_e;
   state_e state, state_nxt;

   logic [ClkDivWidth-1:0]  div_cnt;
   logic                    div_hit, rise_tick, fall_tick;
   logic [5:0]              idx_q;
   logic [1:0]              type_q;
   logic [TimeoutWidth-1:0] tmo_q, tmo_cnt;
   logic [47:0]             token;
   logic [7:0]              bit_cnt;
   logic [126:0]            rx;
   logic [127:0]            rx_nxt;
   logic                    tmo_hit, rx_last, is_long;
   logic [119:0]            rsp;
   logic                    t_err, c_err, e_err, i_err;

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
      end
      return c;
   endfunction

   assign div_hit   = sd_clk_en_i && (div_cnt == clk_div_i);
   assign rise_tick = div_hit && !sd_clk_o;
   assign fall_tick = div_hit && sd_clk_o;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         div_cnt  <= '0;
         sd_clk_o <= 1'b0;
      end else if (!sd_clk_en_i) begin
         div_cnt  <= '0;
         sd_clk_o <= 1'b0;
      end else if (div_hit) begin
         div_cnt  <= '0;
         sd_clk_o <= !sd_clk_o;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
      end

   // rx was cleared on the start bit, so rx_nxt[47] reads back as that start bit
   assign rx_nxt  = {rx, sd_cmd_i};
   assign is_long = (type_q == 2'b10);
   assign rx_last = (bit_cnt == (is_long ? 8'd134 : 8'd46));
   assign tmo_hit = ((tmo_cnt + 1'b1) == tmo_q);

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (cmd.cmd_valid_i) state_nxt = TX;
         TX:         if (fall_tick && bit_cnt == 8'd48)
                        state_nxt = (type_q == 2'b00) ? DONE : WAIT_START;
         WAIT_START: if (rise_tick) begin
                        if (!sd_cmd_i)    state_nxt = RX;
                        else if (tmo_hit) state_nxt = DONE;
                     end
         RX:         if (rise_tick && rx_last) state_nxt = DONE;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         idx_q       <= '0;
         type_q      <= '0;
         tmo_q       <= '0;
         tmo_cnt     <= '0;
         token       <= '0;
         bit_cnt     <= '0;
         rx          <= '0;
         rsp         <= '0;
         t_err       <= 1'b0;
         c_err       <= 1'b0;
         e_err       <= 1'b0;
         i_err       <= 1'b0;
         sd_cmd_o    <= 1'b1;
         sd_cmd_oe_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd.cmd_valid_i) begin
               idx_q   <= cmd.cmd_index_i;
               type_q  <= cmd.rsp_type_i;
               tmo_q   <= (timeout_i == '0) ? TimeoutWidth'(1) : timeout_i;
               tmo_cnt <= '0;
               bit_cnt <= '0;
               token   <= {2'b01, cmd.cmd_index_i, cmd.cmd_arg_i,
                           crc7({2'b01, cmd.cmd_index_i, cmd.cmd_arg_i}), 1'b1};
               t_err   <= 1'b0;
               c_err   <= 1'b0;
               e_err   <= 1'b0;
               i_err   <= 1'b0;
            end
            TX: if (fall_tick) begin
               if (bit_cnt == 8'd48) begin
                  sd_cmd_oe_o <= 1'b0;
                  sd_cmd_o    <= 1'b1;
                  bit_cnt     <= '0;
               end else begin
                  sd_cmd_oe_o <= 1'b1;
                  sd_cmd_o    <= token[47];
                  token       <= {token[46:0], 1'b0};
                  bit_cnt     <= bit_cnt + 1'b1;
               end
            end
            WAIT_START: if (rise_tick) begin
               if (!sd_cmd_i) begin
                  rx      <= '0;
                  bit_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_hit) t_err <= 1'b1;
               end
            end
            RX: if (rise_tick) begin
               rx      <= rx_nxt[126:0];
               bit_cnt <= bit_cnt + 1'b1;
               if (rx_last) begin
                  e_err <= !rx_nxt[0];
                  if (is_long) begin
                     rsp <= rx_nxt[127:8];
                  end else begin
                     rsp <= {88'd0, rx_nxt[39:8]};
                     if (type_q == 2'b01) begin
                        c_err <= (rx_nxt[7:1] != crc7(rx_nxt[47:8]));
                        i_err <= (rx_nxt[45:40] != idx_q);
                     end
                  end
               end
            end
            default: ;
         endcase
      end

   assign cmd.cmd_ready_o   = (state == IDLE);
   assign cmd.inhibit_o     = (state != IDLE);
   assign cmd.done_o        = (state == DONE);
   assign cmd.rsp_o         = rsp;
   assign cmd.timeout_err_o = t_err;
   assign cmd.crc_err_o     = c_err;
   assign cmd.end_err_o     = e_err;
   assign cmd.index_err_o   = i_err;
endmodule

// File: tb/tb_sdhci_cmd_engine.sv
// Bench for sdhci_cmd_engine: acts as the SD card, checks tokens, responses,
// error flags and handshake against a transaction-level model.
`timescale 1ns/1ps
module tb_sdhci_cmd_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [9:0]  div = 10'd1;
   logic [15:0] tmo = 16'd0;
   logic        sclk, cmd_o, oe;
   logic        cmd_in = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int rise_cnt = 0;

   logic [119:0] exp_rsp = '0;
   logic         exp_to = 0, exp_crc = 0, exp_end = 0, exp_idx = 0;
   logic         exp_timeout_case = 0;
   int           exp_rises = 0;

   always #5 clk = ~clk;

   sdhci_cmd_engine_if bus();

   sdhci_cmd_engine dut (
      .clk_i(clk), .rst_ni(rst_n), .sd_clk_en_i(en), .clk_div_i(div),
      .timeout_i(tmo), .cmd(bus.slave), .sd_clk_o(sclk), .sd_cmd_o(cmd_o),
      .sd_cmd_oe_o(oe), .sd_cmd_i(cmd_in)
   );

   function automatic void chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
   function automatic logic [6:0] model_crc(input logic [39:0] m);
      logic [46:0] v;
      v = {m, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (v[i]) v[i-:8] = v[i-:8] ^ 8'h89;
      return v[6:0];
   endfunction

   function automatic logic [47:0] make_token(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, model_crc({2'b01, idx, arg}), 1'b1};
   endfunction

   function automatic logic [47:0] make_r48(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b00, idx, arg, model_crc({2'b00, idx, arg}), 1'b1};
   endfunction

   task automatic wait_fall(output logic ok);
      logic p;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         p = sclk;
         @(negedge clk);
         if (p && !sclk) begin
            ok = 1'b1;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_fall: no sd_clk falling edge within 4000 cycles");
   endtask

   // Per-cycle checker; on every done_o it compares against the model
   logic sclk_p = 0, oe_p = 0, en_p = 1, done_p = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         rise_cnt = 0;
         sclk_p = 0; oe_p = 0; done_p = 0; en_p = en;
      end else begin
         chk("ready_vs_inhibit", 120'(bus.cmd_ready_o), 120'(!bus.inhibit_o));
         if (!oe) chk("released_line_high", 120'(cmd_o), 120'd1);
         if (!en && !en_p) chk("clk_frozen_low", 120'(sclk), 120'd0);
         if (oe_p && !oe) rise_cnt = 0;
         if (!sclk_p && sclk) rise_cnt++;
         if (bus.done_o) begin
            done_cnt++;
            chk("done_one_cycle", 120'(done_p), 120'd0);
            chk("done_inhibit", 120'(bus.inhibit_o), 120'd1);
            chk("rsp", bus.rsp_o, exp_rsp);
            chk("timeout_err", 120'(bus.timeout_err_o), 120'(exp_to));
            chk("crc_err", 120'(bus.crc_err_o), 120'(exp_crc));
            chk("end_err", 120'(bus.end_err_o), 120'(exp_end));
            chk("index_err", 120'(bus.index_err_o), 120'(exp_idx));
            if (exp_timeout_case) chk("timeout_edges", 120'(rise_cnt), 120'(exp_rises));
         end
         sclk_p = sclk; oe_p = oe; en_p = en; done_p = bus.done_o;
      end
   end

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                          input logic [15:0] tmo_v, input logic has_reply, input logic [135:0] r,
                          input int delay, input logic busy_poke, output logic [47:0] tok);
      logic ok;
      int   d0, len;
      exp_to = 0; exp_crc = 0; exp_end = 0; exp_idx = 0; exp_timeout_case = 0;
      len = (typ == 2'b10) ? 136 : 48;
      if (typ != 2'b00 && !has_reply) begin
         exp_to = 1;
         exp_timeout_case = 1;
         exp_rises = (tmo_v == 0) ? 1 : int'(tmo_v);
      end else if (typ == 2'b10) begin
         exp_rsp = r[127:8];
         exp_end = !r[0];
      end else if (typ != 2'b00) begin
         exp_rsp = {88'd0, r[39:8]};
         exp_end = !r[0];
         exp_crc = (typ == 2'b01) && (r[7:1] != model_crc(r[47:8]));
         exp_idx = (typ == 2'b01) && (r[45:40] != idx);
      end
      tok = '0;
      for (int i = 0; i < 5000 && !bus.cmd_ready_o; i++) @(negedge clk);
      @(negedge clk);
      bus.cmd_valid_i = 1'b1; bus.cmd_index_i = idx; bus.cmd_arg_i = arg;
      bus.rsp_type_i = typ; tmo = tmo_v;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      d0 = done_cnt;
      for (int nb = 0; nb < 48; nb++) begin
         wait_fall(ok);
         if (!ok) return;
         chk("tx_oe", 120'(oe), 120'd1);
         tok = {tok[46:0], cmd_o};
         if (busy_poke && nb == 10) begin
            bus.cmd_valid_i = 1'b1; bus.cmd_index_i = 6'h2A; bus.rsp_type_i = 2'b00;
         end
         if (busy_poke && nb == 20) bus.cmd_valid_i = 1'b0;
      end
      chk("token", 120'(tok), 120'(make_token(idx, arg)));
      if (typ != 2'b00 && has_reply) begin
         wait_fall(ok);
         if (!ok) return;
         chk("tx_release", 120'(oe), 120'd0);
         for (int k = 1; k < delay; k++) begin
            wait_fall(ok);
            if (!ok) return;
         end
         for (int b = len - 1; b >= 0; b--) begin
            wait_fall(ok);
            if (!ok) return;
            cmd_in = r[b];
         end
         wait_fall(ok);
         cmd_in = 1'b1;
      end
      for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
      chk("done_seen", 120'(done_cnt - d0 > 0), 120'd1);
      @(negedge clk);
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0]  tok;
      logic [135:0] r;
      logic [127:0] rnd;
      logic [5:0]   ri;
      logic [31:0]  ra;
      logic [1:0]   rt;
      logic [15:0]  rtmo;
      logic         rep, seen_oe;
      int           c;

      bus.cmd_valid_i = 1'b0; bus.cmd_index_i = '0; bus.cmd_arg_i = '0; bus.rsp_type_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 120'(bus.cmd_ready_o), 120'd1);
      chk("rst_inhibit", 120'(bus.inhibit_o), 120'd0);
      chk("rst_oe", 120'(oe), 120'd0);
      chk("rst_cmd_line", 120'(cmd_o), 120'd1);
      chk("rst_sd_clk", 120'(sclk), 120'd0);
      chk("rst_done", 120'(bus.done_o), 120'd0);
      chk("rst_rsp", bus.rsp_o, 120'd0);
      chk("rst_flags", 120'({bus.timeout_err_o, bus.crc_err_o, bus.end_err_o, bus.index_err_o}), 120'd0);
      chk("model_crc_cmd0", 120'(model_crc(40'h4000000000)), 120'h4A);
      chk("model_crc_cmd8", 120'(model_crc(40'h48000001AA)), 120'h43);
      chk("model_crc_r7", 120'(model_crc(40'h08000001AA)), 120'h09);
      rst_n = 1'b1;
      @(negedge clk);

      div = 10'd1;
      run_cmd(6'd0, 32'h0, 2'b00, 16'd0, 1'b0, '0, 0, 1'b0, tok);
      chk("cmd0_token", 120'(tok), 120'h400000000095);

      r = 136'(48'h08000001AA13);
      run_cmd(6'd8, 32'h1AA, 2'b01, 16'd64, 1'b1, r, 5, 1'b0, tok);
      chk("cmd8_token", 120'(tok), 120'h48000001AA87);
      chk("cmd8_rsp", bus.rsp_o, 120'h1AA);
      chk("cmd8_flags", 120'({bus.timeout_err_o, bus.crc_err_o, bus.end_err_o, bus.index_err_o}), 120'd0);

      r = 136'(48'h08000001AA15);
      run_cmd(6'd8, 32'h1AA, 2'b01, 16'd64, 1'b1, r, 5, 1'b0, tok);
      chk("cmd8_bad_crc", 120'(bus.crc_err_o), 120'd1);
      chk("cmd8_bad_crc_rsp", bus.rsp_o, 120'h1AA);

      r = 136'(make_r48(6'd9, 32'h1AA));
      run_cmd(6'd8, 32'h1AA, 2'b01, 16'd64, 1'b1, r, 5, 1'b0, tok);
      chk("cmd8_bad_index", 120'(bus.index_err_o), 120'd1);

      run_cmd(6'd13, 32'h12340000, 2'b01, 16'd10, 1'b0, '0, 0, 1'b0, tok);
      chk("timeout10_flag", 120'(bus.timeout_err_o), 120'd1);
      run_cmd(6'd13, 32'h12340000, 2'b01, 16'd0, 1'b0, '0, 0, 1'b0, tok);
      chk("timeout0_flag", 120'(bus.timeout_err_o), 120'd1);

      r = {8'h3F, 120'h0102030405060708090A0B0C0D0E0F, 8'hFF};
      run_cmd(6'd2, 32'h0, 2'b10, 16'd64, 1'b1, r, 3, 1'b0, tok);
      chk("r2_rsp", bus.rsp_o, 120'h0102030405060708090A0B0C0D0E0F);
      chk("r2_no_crc_err", 120'(bus.crc_err_o), 120'd0);

      r = 136'({2'b00, 6'h3F, 32'hDEADBEEF, 7'h55, 1'b1});
      run_cmd(6'd41, 32'h40FF8000, 2'b11, 16'd64, 1'b1, r, 4, 1'b0, tok);
      chk("r3_flags", 120'({bus.timeout_err_o, bus.crc_err_o, bus.end_err_o, bus.index_err_o}), 120'd0);
      chk("r3_rsp", bus.rsp_o, 120'hDEADBEEF);

      fork
         run_cmd(6'd17, 32'hCAFE0001, 2'b00, 16'd0, 1'b0, '0, 0, 1'b0, tok);
         begin
            repeat (60) @(negedge clk);
            en = 1'b0;
            repeat (40) @(negedge clk);
            en = 1'b1;
         end
      join

      run_cmd(6'd7, 32'h00010000, 2'b00, 16'd0, 1'b0, '0, 0, 1'b1, tok);
      seen_oe = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (oe || bus.inhibit_o) seen_oe = 1'b1;
      end
      chk("busy_request_ignored", 120'(seen_oe), 120'd0);

      for (int i = 0; i < 5000 && !bus.cmd_ready_o; i++) @(negedge clk);
      bus.cmd_valid_i = 1'b1; bus.cmd_index_i = 6'd55; bus.cmd_arg_i = 32'h0; bus.rsp_type_i = 2'b01;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      for (int nb = 0; nb < 20; nb++) wait_fall(rep);
      rst_n = 1'b0;
      #1;
      chk("midtx_rst_oe", 120'(oe), 120'd0);
      chk("midtx_rst_ready", 120'(bus.cmd_ready_o), 120'd1);
      chk("midtx_rst_inhibit", 120'(bus.inhibit_o), 120'd0);
      chk("midtx_rst_line", 120'(cmd_o), 120'd1);
      chk("midtx_rst_rsp", bus.rsp_o, 120'd0);
      exp_rsp = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 24; n++) begin
         div = 10'($urandom_range(0, 3));
         ri  = 6'($urandom);
         ra  = $urandom;
         rt  = 2'($urandom_range(0, 3));
         rep = (rt != 2'b00) && ($urandom_range(0, 3) != 0);
         rtmo = rep ? 16'd64 : 16'($urandom_range(0, 12));
         c = $urandom_range(0, 3);
         if (rt == 2'b10) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            r = {8'h3F, rnd[119:0], rnd[127:121], 1'b1};
            if (c == 3) r[0] = 1'b0;
         end else begin
            r = 136'(make_r48(ri, 32'($urandom)));
            if (c == 1) r[3] = ~r[3];
            if (c == 2) r[45:40] = ~ri;
            if (c == 3) r[0] = 1'b0;
         end
         run_cmd(ri, ra, rt, rtmo, rep, r, $urandom_range(2, 8), 1'b0, tok);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sdhci_cmd_engine.md
Name: sdhci_cmd_engine

Overview:
Command-line engine for the SDHCI peripheral. Serialises one SD command token (start, transmission, index, argument, CRC7, end) onto the CMD line and optionally captures a 48- or 136-bit response with CRC7, index, end-bit and timeout checking. Generates the SD clock from a programmable divider. The register block drives the request fields and consumes the inhibit, done, response and error outputs.

Parameters:
ClkDivWidth, 10, width of clk_div_i; sd_clk half-period is clk_div_i+1 system cycles.
TimeoutWidth, 16, width of timeout_i, counted in sd_clk rising edges.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
sd_clk_en_i  in  1  enable SD clock toggling
clk_div_i  in  ClkDivWidth  SD clock divider
timeout_i  in  TimeoutWidth  response start-bit timeout; 0 is treated as 1
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  engine idle, request accepted when valid&ready
cmd_index_i  in  6  command index
cmd_arg_i  in  32  command argument
rsp_type_i  in  2  00 none, 01 48-bit checked, 10 136-bit, 11 48-bit unchecked (R3)
inhibit_o  out  1  command in flight (Command Inhibit CMD)
done_o  out  1  one-cycle pulse at command completion
rsp_o  out  120  captured response
timeout_err_o, crc_err_o, end_err_o, index_err_o  out  1 each  error flags, valid from done_o until next accept
sd_clk_o  out  1  SD clock
sd_cmd_o  out  1  CMD line output value
sd_cmd_oe_o  out  1  CMD line output enable
sd_cmd_i  in  1  CMD line input, already synchronised

Behaviour:
- Reset: all outputs 0 except cmd_ready_o=1, sd_cmd_o=1; state IDLE; rsp_o and error flags cleared.
- Divider: counter counts to clk_div_i then toggles sd_clk_o; rise_tick/fall_tick are internal one-cycle strobes. sd_clk_en_i=0 holds sd_clk_o low and freezes the FSM at its current bit. clk_div_i is sampled live; changing it mid-command is unsupported.
- Accept: cmd_valid_i&cmd_ready_o in IDLE latches index, arg, rsp_type and timeout. Next cycle inhibit_o=1, cmd_ready_o=0, error flags cleared. Requests while busy are ignored.
- States: IDLE -> TX -> (rsp none) DONE | WAIT_START -> RX -> DONE -> IDLE.
- TX: 48 bits MSB first, each driven on fall_tick: 0, 1, index[5:0], arg[31:0], CRC7 over the preceding 40 bits (polynomial x^7+x^3+1, init 0), 1. sd_cmd_oe_o=1 from the first fall_tick until the fall_tick after the end bit. Then oe=0 and sd_cmd_o=1.
- WAIT_START: on each rise_tick, sd_cmd_i=0 -> RX. Otherwise count; count reaching the latched timeout sets timeout_err_o -> DONE.
- RX: samples on rise_tick, 47 more bits (48-bit) or 135 more bits (136-bit) after the start bit.
  - 48-bit: rsp_o[31:0]=bits[39:8]; rsp_o[119:32]=0.
  - 136-bit: rsp_o[119:0]=bits[127:8].
  - Transmission bit is not checked.
  - End bit != 1 sets end_err_o (all types).
  - Type 01 only: crc_err_o if received bits[7:1] != CRC7 of bits[47:8]; index_err_o if bits[45:40] != latched index.
  - Types 10 and 11: no CRC or index check.
- DONE: one cycle. done_o=1; inhibit_o falls and cmd_ready_o rises in the following cycle (IDLE). A new command may be accepted in that IDLE cycle.
- rsp_o and error flags hold until the next accept.
- Reset mid-operation: immediately returns to reset values; CMD line released (oe=0).

Test Plan:
- CMD0 arg 0, type 00, clk_div 1 -> 48 driven bits equal 0x400000000095, MSB first on fall edges. done_o pulses once after the end bit; no errors; inhibit_o high throughout.
- CMD8 arg 0x000001AA, type 01; card replies 0x080000_01AA13 after 5 sd clocks -> command token 0x48000001AA87; rsp_o[31:0]=0x000001AA; all error flags 0.
- Same as previous but response CRC byte 0x15 -> crc_err_o=1 and rsp_o still captured. Reply index 9 instead -> index_err_o=1.
- Type 01, timeout_i=10, CMD line held high -> timeout_err_o=1 and done_o exactly 10 sd_clk rising edges after release. Repeat with timeout_i=0 -> timeout after 1 edge.
- Type 10 with a 136-bit reply of an incrementing byte pattern -> rsp_o[119:0] equals reply bits[127:8]; crc_err_o=0 even with a corrupted CRC. Type 11 with a corrupted CRC and index -> no errors.
- Reset asserted mid-TX, and a second cmd_valid_i while busy -> reset gives oe=0, cmd_ready_o=1, inhibit_o=0; the busy-time request is ignored (no second token).
